// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment/anode encodings and snapshot type for the 4-digit scanner
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;

  typedef struct packed {
    logic [3:0][3:0] digits;
    logic [3:0]      dp;
    logic            lz;
  } snap_t;

endpackage

// File: rtl/seg7_if.sv
// rtl/seg7_if.sv - digit inputs and display drive signals of the 4-digit scanner
interface seg7_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_in;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output digit0, digit1, digit2, digit3, dp_in, blank_lz,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, dp_in, blank_lz,
    output an, seg, dp, frame_start
  );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low 7-segment decode
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan4.sv
// rtl/seg7_scan4.sv - 4-digit multiplexed 7-segment scanner with frame snapshot and leading-zero blanking
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic    clk,
  input  logic    rst,
  seg7_if.slave   bus
);

  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0] p;
  logic [1:0]    i;
  snap_t         snap;
  logic          capture;
  logic [3:0]    blank;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          fs_q;

  assign capture = (p == '0) && (i == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      p    <= '0;
      i    <= 2'd0;
      snap <= '0;
      fs_q <= 1'b0;
    end else begin
      if (p == PW'(SCAN_DIV - 1)) begin
        p <= '0;
        i <= i + 2'd1;
      end else begin
        p <= p + PW'(1);
      end
      if (capture) begin
        snap.digits <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
        snap.dp     <= bus.dp_in;
        snap.lz     <= bus.blank_lz;
      end
      fs_q <= capture;
    end
  end

  // A digit is blanked only while it and every higher digit read zero.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = snap.lz && (snap.digits[3] == 4'd0);
    blank[2] = blank[3] && (snap.digits[2] == 4'd0);
    blank[1] = blank[2] && (snap.digits[1] == 4'd0);
  end

  assign cur_digit = snap.digits[i];

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else if ((p < PW'(BLANK_CYC)) || blank[i]) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << i);
      seg_q <= cur_seg;
      dp_q  <= ~snap.dp[i];
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// tb/tb_seg7_scan4.sv - directed self-checking bench for seg7_scan4 (SCAN_DIV=8, BLANK_CYC=2)
module tb_seg7_scan4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   tp = 0;
  int   ti = 0;

  seg7_if bus ();

  seg7_scan4 #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0, input logic [3:0] dpi, input logic lz);
    bus.digit3   = d3;
    bus.digit2   = d2;
    bus.digit1   = d1;
    bus.digit0   = d0;
    bus.dp_in    = dpi;
    bus.blank_lz = lz;
  endtask

  // es = {slot3,slot2,slot1,slot0} segment codes; act = slots that light; dpm = slots with dp lit
  task automatic cyc(input logic [27:0] es, input logic [3:0] act, input logic [3:0] dpm);
    int p0;
    int i0;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    logic       efs;
    p0 = tp;
    i0 = ti;
    @(posedge clk);
    @(negedge clk);
    efs = (p0 == 0) && (i0 == 0);
    if (p0 < 2 || !act[i0]) begin
      ean  = 4'hF;
      eseg = 7'h7F;
      edp  = 1'b1;
    end else begin
      ean  = ~(4'b0001 << i0);
      eseg = es[i0*7 +: 7];
      edp  = ~dpm[i0];
    end
    chk($sformatf("an s%0d p%0d", i0, p0), bus.an, ean);
    chk($sformatf("seg s%0d p%0d", i0, p0), bus.seg, eseg);
    chk($sformatf("dp s%0d p%0d", i0, p0), bus.dp, edp);
    chk($sformatf("frame_start s%0d p%0d", i0, p0), bus.frame_start, efs);
    chk($sformatf("an_onehot s%0d p%0d", i0, p0), ($countones(~bus.an) <= 1), 1);
    if (tp == 7) begin
      tp = 0;
      ti = (ti + 1) % 4;
    end else begin
      tp++;
    end
  endtask

  task automatic frame(input logic [27:0] es, input logic [3:0] act, input logic [3:0] dpm);
    repeat (32) cyc(es, act, dpm);
  endtask

  task automatic rst_cyc();
    @(posedge clk);
    @(negedge clk);
    chk("rst an", bus.an, 4'hF);
    chk("rst seg", bus.seg, 7'h7F);
    chk("rst dp", bus.dp, 1'b1);
    chk("rst frame_start", bus.frame_start, 1'b0);
    tp = 0;
    ti = 0;
  endtask

  initial begin
    set_in(4'd4, 4'd3, 4'd2, 4'd1, 4'b0000, 1'b0);
    rst = 1'b1;
    repeat (3) rst_cyc();
    rst = 1'b0;

    // plain scan, two frames to show the 32-cycle repeat
    frame({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 4'h0);
    frame({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 4'h0);

    // leading zeros blanked, dp request on a blanked digit stays dark
    set_in(4'd0, 4'd0, 4'd0, 4'd5, 4'b1001, 1'b1);
    frame({7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b0001, 4'b1001);

    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'b0000);

    // interior zero after a nonzero digit is shown
    set_in(4'd0, 4'd1, 4'd0, 4'd3, 4'b0000, 1'b1);
    frame({7'h7F, 7'h79, 7'h40, 7'h30}, 4'b0111, 4'b0000);

    // out-of-range values show a dash; decimal point on slot 1
    set_in(4'hF, 4'd3, 4'hC, 4'd1, 4'b0010, 1'b0);
    frame({7'h3F, 7'h30, 7'h3F, 7'h79}, 4'hF, 4'b0010);

    // input change mid-frame is not visible until the next snapshot
    set_in(4'd1, 4'd7, 4'd3, 4'd2, 4'b0000, 1'b0);
    repeat (12) cyc({7'h79, 7'h78, 7'h30, 7'h24}, 4'hF, 4'h0);
    bus.digit2 = 4'd8;
    repeat (20) cyc({7'h79, 7'h78, 7'h30, 7'h24}, 4'hF, 4'h0);
    repeat (21) cyc({7'h79, 7'h00, 7'h30, 7'h24}, 4'hF, 4'h0);

    // reset in the middle of slot 2 aborts it, then the scan restarts at slot 0
    rst = 1'b1;
    repeat (2) rst_cyc();
    rst = 1'b0;
    frame({7'h79, 7'h00, 7'h30, 7'h24}, 4'hF, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan4.md
SEG7_SCAN4 -- requirements
Module: seg7_scan4

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range is 4 or more.
REQ-002 SHALL have parameter BLANK_CYC, default 16: anode-off guard cycles at the start of each slot; legal range is 1 to SCAN_DIV-2.
REQ-003 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port digit0..digit3, input, 4 bits each: BCD digits, with digit0 least significant; these are driven by the cascaded mod-10 counter chain.
REQ-006 SHALL have port dp_in, input, 4 bits: per-digit decimal point request, active-high.
REQ-007 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-008 SHALL have port an, output, 4 bits: digit anodes, active-low, where bit i selects digit i.
REQ-009 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp, output, 1 bit: decimal point segment, active-low.
REQ-011 SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new snapshot is loaded.

Function
REQ-012 Prescaler p SHALL count 0..SCAN_DIV-1 and wrap to 0; it advances every cycle while rst is low.
REQ-013 Slot index i (2 bits) SHALL advance on the cycle where p==SCAN_DIV-1, wrapping 3->0.
REQ-014 On every cycle with p==0 and i==0, digits, dp_in and blank_lz SHALL be captured into a snapshot; display SHALL use only the snapshot (no mid-frame tearing).
REQ-015 frame_start SHALL be registered high for exactly the cycle after the snapshot-capture cycle; it is low otherwise.
REQ-016 an, seg and dp SHALL be registered: they reflect (i, p, snapshot) of the previous cycle, giving latency 1.
REQ-017 During guard cycles (p < BLANK_CYC), outputs SHALL be an=4'hF, seg=7'h7F, dp=1.
REQ-018 For p >= BLANK_CYC with digit i not blanked, outputs SHALL be an = ~(1<<i), seg = decode(snapshot digit i), dp = ~snapshot dp_in[i].
REQ-019 Decode table (active-low hex) SHALL be: 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10; values 10-15 SHALL produce 3F (dash, segment g only).
REQ-020 When the snapshot blank_lz is 1, digit k (k=3..1) SHALL be blanked if digit k and all higher digits are 0; digit0 SHALL never be blanked.
REQ-021 A blanked digit SHALL output an=4'hF, seg=7'h7F, dp=1 for its whole slot, including when dp_in is set.
REQ-022 At most one an bit SHALL be low in any cycle.

Reset
REQ-023 While rst is high: p=0, i=0, snapshot=0, an=4'hF, seg=7'h7F, dp=1, frame_start=0.
REQ-024 The first cycle after rst falls SHALL be a capture cycle (p=0, i=0), so frame_start is high in the following cycle.
REQ-025 rst asserted mid-frame SHALL abort the current slot immediately at the next edge; there is no partial-slot completion.

Structure
REQ-026 Package seg7_pkg SHALL hold the segment encoding constants (SEG_0..SEG_9, SEG_DASH=7'h3F, SEG_OFF=7'h7F) and the anode-off constant AN_OFF=4'hF.
REQ-027 A sub-module seg7_decode SHALL implement the combinational 4-bit to 7-segment decode; the prescaler, index, snapshot and blanking logic SHALL live in seg7_scan4.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-028 Reset: hold rst 3 cycles -> an=F, seg=7F, dp=1, frame_start=0 throughout; frame_start=1 on the 2nd cycle after release.
REQ-029 Scan: digits 4,3,2,1 (digit3..0) with blank_lz=0 -> per slot, 2 cycles with an=F, then 6 cycles of an=E/seg=79, D/24, B/30, 7/19; the sequence repeats every 32 cycles.
REQ-030 Blanking: digits 0,0,0,5 with blank_lz=1 -> only an=E/seg=12 is ever active; digits 0,0,0,0 -> only an=E/seg=40 is active.
REQ-031 Dash and decimal point: digit1=4'hC, dp_in=4'b0010 -> in slot 1, seg=3F and dp=0.
REQ-032 Tearing and reset: change digit2 from 7 to 8 during slot 1 -> slot 2 still shows 78 until after the next frame_start; assert rst during slot 2 -> next cycle an=F, then scan restarts at slot 0.
